// File: rtl/difftest_arch_int_reg_tx.sv
`default_nettype none
// ============================================================================
// Module   : difftest_arch_int_reg_tx
// Purpose  : Snapshots x0..x31 plus core id and streams them as a 33-beat
//            packet (one header beat, then 32 register beats).
// Revision : 1.0 - initial release
// ============================================================================
module difftest_arch_int_reg_tx #(
  parameter logic [7:0] PKT_TAG = 8'hA1,
  parameter int         SEQ_W   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [63:0] io_value_0,
  input  logic [63:0] io_value_1,
  input  logic [63:0] io_value_2,
  input  logic [63:0] io_value_3,
  input  logic [63:0] io_value_4,
  input  logic [63:0] io_value_5,
  input  logic [63:0] io_value_6,
  input  logic [63:0] io_value_7,
  input  logic [63:0] io_value_8,
  input  logic [63:0] io_value_9,
  input  logic [63:0] io_value_10,
  input  logic [63:0] io_value_11,
  input  logic [63:0] io_value_12,
  input  logic [63:0] io_value_13,
  input  logic [63:0] io_value_14,
  input  logic [63:0] io_value_15,
  input  logic [63:0] io_value_16,
  input  logic [63:0] io_value_17,
  input  logic [63:0] io_value_18,
  input  logic [63:0] io_value_19,
  input  logic [63:0] io_value_20,
  input  logic [63:0] io_value_21,
  input  logic [63:0] io_value_22,
  input  logic [63:0] io_value_23,
  input  logic [63:0] io_value_24,
  input  logic [63:0] io_value_25,
  input  logic [63:0] io_value_26,
  input  logic [63:0] io_value_27,
  input  logic [63:0] io_value_28,
  input  logic [63:0] io_value_29,
  input  logic [63:0] io_value_30,
  input  logic [63:0] io_value_31,
  input  logic [7:0]  io_coreid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [7:0]  c_REG_COUNT = 8'h20;
  localparam logic [15:0] c_DROP_MAX  = 16'hFFFF;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [4:0]        r_idx;
  logic [SEQ_W-1:0]  r_seq;
  logic [15:0]       r_drop_cnt;
  logic [63:0]       r_snap [32];
  logic [7:0]        r_coreid_snap;
  logic [63:0]       w_value [32];
  logic [23:0]       w_seq24;
  logic              w_active;
  logic              w_hs;
  logic              w_capture;
  logic              w_drop;

  assign w_value[0]  = io_value_0;
  assign w_value[1]  = io_value_1;
  assign w_value[2]  = io_value_2;
  assign w_value[3]  = io_value_3;
  assign w_value[4]  = io_value_4;
  assign w_value[5]  = io_value_5;
  assign w_value[6]  = io_value_6;
  assign w_value[7]  = io_value_7;
  assign w_value[8]  = io_value_8;
  assign w_value[9]  = io_value_9;
  assign w_value[10] = io_value_10;
  assign w_value[11] = io_value_11;
  assign w_value[12] = io_value_12;
  assign w_value[13] = io_value_13;
  assign w_value[14] = io_value_14;
  assign w_value[15] = io_value_15;
  assign w_value[16] = io_value_16;
  assign w_value[17] = io_value_17;
  assign w_value[18] = io_value_18;
  assign w_value[19] = io_value_19;
  assign w_value[20] = io_value_20;
  assign w_value[21] = io_value_21;
  assign w_value[22] = io_value_22;
  assign w_value[23] = io_value_23;
  assign w_value[24] = io_value_24;
  assign w_value[25] = io_value_25;
  assign w_value[26] = io_value_26;
  assign w_value[27] = io_value_27;
  assign w_value[28] = io_value_28;
  assign w_value[29] = io_value_29;
  assign w_value[30] = io_value_30;
  assign w_value[31] = io_value_31;

  assign w_active  = (r_state == S_HDR) || (r_state == S_DATA);
  assign w_hs      = w_active && out_ready;
  assign w_seq24   = 24'(r_seq);
  assign out_valid = w_active;
  assign busy      = w_active;
  assign drop_cnt  = r_drop_cnt;

  // Outputs are decoded from registered state only, so they hold during stalls.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    out_data    = 64'h0;
    out_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        out_data = {PKT_TAG, r_coreid_snap, c_REG_COUNT, w_seq24, 16'h0000};
        if (w_hs) w_state_nxt = S_DATA;
        w_drop = enable;
      end
      S_DATA: begin
        out_data = r_snap[r_idx];
        out_last = (r_idx == 5'd31);
        if (w_hs && (r_idx == 5'd31)) begin
          // A request coinciding with the final handshake starts the next packet.
          if (enable) begin
            w_capture   = 1'b1;
            w_state_nxt = S_HDR;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_drop = enable;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 5'd0;
      r_seq      <= '0;
      r_drop_cnt <= 16'h0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_HDR) && w_hs) begin
        r_idx <= 5'd0;
        r_seq <= r_seq + SEQ_W'(1);
      end else if ((r_state == S_DATA) && w_hs) begin
        r_idx <= r_idx + 5'd1;
      end
      if (w_drop && (r_drop_cnt != c_DROP_MAX)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Snapshot buffer has no reset; its contents are meaningless until captured.
  always_ff @(posedge clock) begin
    if (w_capture) begin
      for (int k = 0; k < 32; k++) r_snap[k] <= w_value[k];
      r_coreid_snap <= io_coreid;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_difftest_arch_int_reg_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_difftest_arch_int_reg_tx
// Purpose  : Randomized bench with a beat-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_difftest_arch_int_reg_tx;

  localparam int         SEQ_W = 4;
  localparam logic [7:0] TAG   = 8'hA1;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        out_ready;
  logic [63:0] vals [32];
  logic [7:0]  coreid;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;
  logic [15:0] drop_cnt;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [63:0] q [$];
  int unsigned m_seq;
  int unsigned m_drop;

  always #5 clock = ~clock;

  difftest_arch_int_reg_tx #(.PKT_TAG(TAG), .SEQ_W(SEQ_W)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .io_value_0(vals[0]),   .io_value_1(vals[1]),   .io_value_2(vals[2]),   .io_value_3(vals[3]),
    .io_value_4(vals[4]),   .io_value_5(vals[5]),   .io_value_6(vals[6]),   .io_value_7(vals[7]),
    .io_value_8(vals[8]),   .io_value_9(vals[9]),   .io_value_10(vals[10]), .io_value_11(vals[11]),
    .io_value_12(vals[12]), .io_value_13(vals[13]), .io_value_14(vals[14]), .io_value_15(vals[15]),
    .io_value_16(vals[16]), .io_value_17(vals[17]), .io_value_18(vals[18]), .io_value_19(vals[19]),
    .io_value_20(vals[20]), .io_value_21(vals[21]), .io_value_22(vals[22]), .io_value_23(vals[23]),
    .io_value_24(vals[24]), .io_value_25(vals[25]), .io_value_26(vals[26]), .io_value_27(vals[27]),
    .io_value_28(vals[28]), .io_value_29(vals[29]), .io_value_30(vals[30]), .io_value_31(vals[31]),
    .io_coreid(coreid), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .drop_cnt(drop_cnt)
  );

  task automatic model_reset();
    q.delete();
    m_seq  = 0;
    m_drop = 0;
  endtask

  // {valid, busy, last, data} as the reference model predicts them.
  function automatic logic [66:0] exp_bus();
    if (q.size() == 0) return 67'h0;
    return {1'b1, 1'b1, (q.size() == 1), q[0]};
  endfunction

  // Advance the model across one rising edge using the inputs sampled there.
  task automatic model_edge(input logic en, input logic rdy);
    int orig;
    bit hs, last_hs;
    orig    = q.size();
    hs      = (orig > 0) && rdy;
    last_hs = hs && (orig == 1);
    if (hs) void'(q.pop_front());
    if (en) begin
      if ((orig == 0) || last_hs) begin
        q.push_back({TAG, coreid, 8'h20, 24'(m_seq), 16'h0000});
        for (int k = 0; k < 32; k++) q.push_back(vals[k]);
        m_seq = (m_seq + 1) % (1 << SEQ_W);
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
  endtask

  task automatic randomize_vals();
    for (int k = 0; k < 32; k++) vals[k] = {$urandom, $urandom};
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    enable = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    enable = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; out_ready = 1'b1; coreid = 8'h00;
    randomize_vals();
    #1 reset = 1'b1;
    enable = 1'b1;
    model_reset();
    @(negedge clock);
    n_checks++;
    if ({out_valid, busy, out_last, out_data} !== 67'h0) begin
      n_fails++;
      $display("FAIL reset_outputs: got %h expected %h", {out_valid, busy, out_last, out_data}, 67'h0);
    end
    n_checks++;
    if (drop_cnt !== 16'h0) begin
      n_fails++;
      $display("FAIL reset_drop_cnt: got %h expected %h", drop_cnt, 16'h0);
    end
    @(negedge clock);
    reset = 1'b0;
    enable = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_enable_ignored: got busy %b expected 0", busy);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_single();
    for (int k = 0; k < 32; k++) vals[k] = 64'(k * 32'h0101);
    coreid = 8'h03; out_ready = 1'b1;
    for (int c = 0; c < 45; c++) begin
      enable = (c == 5);
      @(negedge clock);
      n_checks++;
      if ({out_valid, busy, out_last, out_data} !== exp_bus()) begin
        n_fails++;
        $display("FAIL single_beat c=%0d: got %h expected %h", c, {out_valid, busy, out_last, out_data}, exp_bus());
      end
      if (c == 6) begin
        n_checks++;
        if (out_data !== 64'hA103_2000_0000_0000) begin
          n_fails++;
          $display("FAIL single_header: got %h expected %h", out_data, 64'hA103_2000_0000_0000);
        end
      end
      if (c == 38) begin
        n_checks++;
        if ((out_last !== 1'b1) || (out_data !== 64'h1F1F)) begin
          n_fails++;
          $display("FAIL single_last: got last %b data %h expected last 1 data 1f1f", out_last, out_data);
        end
      end
      if (c == 39) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fails++;
          $display("FAIL single_busy_end: got %b expected 0", busy);
        end
      end
      model_edge(enable, out_ready);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_backpressure();
    int beats = 0;
    coreid = 8'h7E;
    for (int c = 0; c < 75; c++) begin
      randomize_vals();
      enable    = (c == 2);
      out_ready = c[0];
      @(negedge clock);
      n_checks++;
      if ({out_valid, busy, out_last, out_data} !== exp_bus()) begin
        n_fails++;
        $display("FAIL backpressure_beat c=%0d: got %h expected %h", c, {out_valid, busy, out_last, out_data}, exp_bus());
      end
      if (out_valid && out_ready) beats++;
      model_edge(enable, out_ready);
      @(posedge clock);
      #1;
    end
    n_checks++;
    if (beats != 33) begin
      n_fails++;
      $display("FAIL backpressure_beats: got %0d expected 33", beats);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    coreid = 8'h5A; out_ready = 1'b1;
    for (int c = 0; c < 70; c++) begin
      randomize_vals();
      enable = (c < 40);
      @(negedge clock);
      n_checks++;
      if ({out_valid, busy, out_last, out_data} !== exp_bus()) begin
        n_fails++;
        $display("FAIL b2b_beat c=%0d: got %h expected %h", c, {out_valid, busy, out_last, out_data}, exp_bus());
      end
      n_checks++;
      if (drop_cnt !== m_drop[15:0]) begin
        n_fails++;
        $display("FAIL b2b_drop_cnt c=%0d: got %h expected %h", c, drop_cnt, m_drop[15:0]);
      end
      if (c == 34) begin
        n_checks++;
        if ((drop_cnt !== 16'd32) || (out_data[39:16] !== 24'd1)) begin
          n_fails++;
          $display("FAIL b2b_packet_b: got drop %0d seq %0d expected drop 32 seq 1", drop_cnt, out_data[39:16]);
        end
      end
      model_edge(enable, out_ready);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_seq_wrap();
    int npk = (1 << SEQ_W) + 1;
    apply_reset();
    coreid = 8'hC4; out_ready = 1'b1;
    for (int c = 0; c < npk * 33 + 3; c++) begin
      randomize_vals();
      enable = (c <= (npk - 1) * 33);
      @(negedge clock);
      n_checks++;
      if ({out_valid, busy, out_last, out_data} !== exp_bus()) begin
        n_fails++;
        $display("FAIL wrap_beat c=%0d: got %h expected %h", c, {out_valid, busy, out_last, out_data}, exp_bus());
      end
      if (c == (npk - 1) * 33 + 1) begin
        n_checks++;
        if (out_data[39:16] !== 24'd0) begin
          n_fails++;
          $display("FAIL wrap_last_seq: got %h expected 000000", out_data[39:16]);
        end
      end
      model_edge(enable, out_ready);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_drop_sat();
    apply_reset();
    coreid = 8'h11; out_ready = 1'b0; enable = 1'b1;
    for (int c = 0; c < 70000; c++) begin
      @(negedge clock);
      if ((c % 4096) == 0) begin
        n_checks++;
        if (({out_valid, busy, out_last, out_data} !== exp_bus()) || (drop_cnt !== m_drop[15:0])) begin
          n_fails++;
          $display("FAIL sat_progress c=%0d: got drop %h expected %h", c, drop_cnt, m_drop[15:0]);
        end
      end
      model_edge(enable, out_ready);
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    n_checks++;
    if (drop_cnt !== 16'hFFFF) begin
      n_fails++;
      $display("FAIL sat_final: got %h expected ffff", drop_cnt);
    end
    enable = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    coreid = 8'h22; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      randomize_vals();
      enable = (c == 0);
      @(negedge clock);
      n_checks++;
      if ({out_valid, busy, out_last, out_data} !== exp_bus()) begin
        n_fails++;
        $display("FAIL mid_beat c=%0d: got %h expected %h", c, {out_valid, busy, out_last, out_data}, exp_bus());
      end
      model_edge(enable, out_ready);
      @(posedge clock);
      #1;
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, busy, out_last, out_data} !== 67'h0) begin
      n_fails++;
      $display("FAIL mid_async_reset: got %h expected %h", {out_valid, busy, out_last, out_data}, 67'h0);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    for (int c = 0; c < 6; c++) begin
      randomize_vals();
      enable = (c == 1);
      @(negedge clock);
      n_checks++;
      if ({out_valid, busy, out_last, out_data} !== exp_bus()) begin
        n_fails++;
        $display("FAIL mid_after c=%0d: got %h expected %h", c, {out_valid, busy, out_last, out_data}, exp_bus());
      end
      if (c == 2) begin
        n_checks++;
        if ((out_valid !== 1'b1) || (out_data[39:16] !== 24'd0)) begin
          n_fails++;
          $display("FAIL mid_seq_restart: got valid %b seq %h expected valid 1 seq 000000", out_valid, out_data[39:16]);
        end
      end
      model_edge(enable, out_ready);
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_seq_wrap();
    test_drop_sat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/difftest_arch_int_reg_tx.md
DIFFTEST_ARCH_INT_REG_TX -- requirements
Module: difftest_arch_int_reg_tx

Interface
REQ-001 SHALL have parameter PKT_TAG, default 8'hA1: tag placed in header-beat bits [63:56].
REQ-002 SHALL have parameter SEQ_W, default 16: width of the packet sequence counter, legal range 1..24.
REQ-003 SHALL have port clock, input, 1: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: snapshot request for the current architectural register state.
REQ-006 SHALL have ports io_value_0 .. io_value_31, input, 64 each: integer registers x0..x31.
REQ-007 SHALL have port io_coreid, input, 8: core identifier.
REQ-008 SHALL have port out_valid, output, 1: a stream beat is presented.
REQ-009 SHALL have port out_ready, input, 1: the downstream sink accepts the beat.
REQ-010 SHALL have port out_data, output, 64: beat payload.
REQ-011 SHALL have port out_last, output, 1: marks the final beat of a packet.
REQ-012 SHALL have port busy, output, 1: a packet is in flight.
REQ-013 SHALL have port drop_cnt, output, 16: count of dropped snapshot requests.

Function
REQ-014 SHALL implement states IDLE, HDR and DATA.
REQ-015 SHALL, in IDLE with enable=1, capture all 32 io_value_* and io_coreid into an internal buffer at the clock edge and enter HDR.
- Latency: enable sampled high in cycle N gives out_valid=1 in cycle N+1.
REQ-016 SHALL drive the header beat in HDR as {PKT_TAG, coreid_snap, 8'h20, seq zero-extended to 24 bits, 16'h0000}.
REQ-017 SHALL, on HDR handshake (out_valid & out_ready), enter DATA with beat index 0.
REQ-018 SHALL present snap_value[idx] in DATA, increment idx on each handshake, and assert out_last only when idx=31.
REQ-019 SHALL provide the following transitions on the idx=31 handshake:
- enable=1 in the same cycle: new snapshot, next state HDR (back-to-back, no bubble);
- otherwise: next state IDLE.
REQ-020 SHALL hold out_data and out_last stable, and keep out_valid asserted, until a handshake occurs; out_valid never drops without a handshake.
REQ-021 SHALL drive out_valid=1 exactly in HDR and DATA; busy=1 in HDR/DATA, 0 in IDLE.
REQ-022 SHALL treat enable=1 while busy (excluding the REQ-019 case) as a dropped request:
- buffer unchanged;
- drop_cnt += 1, saturating at 16'hFFFF.
REQ-023 SHALL increment seq by 1 per captured snapshot, after the header carrying it, wrapping modulo 2^SEQ_W.
REQ-024 SHALL make out_data in IDLE 64'h0 and out_last 0.
REQ-025 SHALL make a packet exactly 33 beats; x0 is transmitted as sampled, with no forcing to zero.

Reset
REQ-026 SHALL, on reset assertion in any state, asynchronously force state=IDLE, out_valid=0, out_last=0, out_data=0, busy=0, idx=0, seq=0, drop_cnt=0.
REQ-027 SHALL abort any partial packet on reset with no resumption; snapshot buffer contents are don't-care after reset.
REQ-028 SHALL ignore enable in the first cycle after reset deassertion only if it is sampled while reset is high.

Verification
REQ-029 Single packet, out_ready=1: io_value_k=k*0x0101, coreid=3, enable pulse at cycle 5 -> header 0xA1_03_20_000000_0000 at cycle 6, data 0x0000..0x1F1F on cycles 7..38, out_last only on cycle 38, busy low at cycle 39.
REQ-030 Backpressure: out_ready toggles 1/0 every cycle -> 33 beats in 66 cycles; data/last stable across each stall; inputs changed after capture do not affect beats.
REQ-031 Drops: enable held high for 40 cycles, out_ready=1 -> packet A (seq 0), back-to-back packet B (seq 1) starting the cycle after A's last beat, drop_cnt=32 after A.
REQ-032 Saturation/wrap: force 70000 drops -> drop_cnt=0xFFFF; send 2^16+1 packets -> last header seq=0x000000.
REQ-033 Reset mid-packet: assert reset asynchronously during beat 10 -> out_valid=0 before the next edge; after release, the next enable yields a header with seq=0.
